// File: rtl/mod_reducer.sv
// Restoring shift-subtract reduction of a signed 2*width-bit value
// modulo an unsigned width-bit modulus, one product bit per cycle.
module mod_reducer #(
  parameter int width = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic signed [2*width-1:0] x,
  input  logic [width-1:0]          p,
  output logic [width-1:0]          r,
  output logic                      done,
  output logic                      err
);

  localparam int XW = 2 * width;
  localparam int CW = $clog2(XW);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t          state;
  logic            sign;
  logic [XW-1:0]   mag;
  logic [width-1:0] pm;
  logic [width-1:0] rem;
  logic [CW-1:0]   cnt;

  logic [XW-1:0]   xu;
  logic [XW-1:0]   x_abs;
  logic [width:0]  t;
  logic [width:0]  d;
  logic [width:0]  pw;

  // Most-negative input negates to 2^(XW-1), which fits as unsigned.
  always_comb begin
    xu    = x;
    x_abs = xu[XW-1] ? (~xu + XW'(1)) : xu;
    pw    = {1'b0, pm};
    t     = {rem, mag[cnt]};
    d     = t - pw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sign  <= 1'b0;
      mag   <= '0;
      pm    <= '0;
      rem   <= '0;
      cnt   <= '0;
      r     <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (enable) begin
            sign  <= xu[XW-1];
            mag   <= x_abs;
            pm    <= p;
            rem   <= '0;
            cnt   <= CW'(XW - 1);
            state <= ITER;
          end
        end
        ITER: begin
          rem <= (t >= pw) ? d[width-1:0] : t[width-1:0];
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (pm == '0) begin
            r   <= '0;
            err <= 1'b1;
          end else if (sign && rem != '0) begin
            r   <= pm - rem;
            err <= 1'b0;
          end else begin
            r   <= rem;
            err <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!enable) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reducer.sv
// Self-checking bench for mod_reducer: directed cases from the
// datapath plus random operands against a plain-arithmetic model.
module tb_mod_reducer;

  localparam int W = 16;

  logic                  clk;
  logic                  reset;
  logic                  enable;
  logic signed [2*W-1:0] x;
  logic [W-1:0]          p;
  logic [W-1:0]          r;
  logic                  done;
  logic                  err;

  int errors = 0;
  int checks = 0;

  mod_reducer #(.width(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .x      (x),
    .p      (p),
    .r      (r),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_mod(
    input logic [2*W-1:0] xv,
    input logic [W-1:0]   pv
  );
    longint v;
    longint m;
    longint pl;
    if (pv == '0) return '0;
    v  = longint'($signed(xv));
    pl = longint'(pv);
    m  = v % pl;
    if (m < 0) m = m + pl;
    return W'(m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture happens on the first edge; done must rise exactly 2W+1
  // edges later and r must stay fixed while done is high and after.
  task automatic run(input logic [2*W-1:0] xv, input logic [W-1:0] pv,
                     input bit pulse, input string tag);
    logic [W-1:0] er;
    er = ref_mod(xv, pv);
    x = xv;
    p = pv;
    enable = 1'b1;
    step();
    x = $urandom;
    p = W'($urandom);
    if (pulse) enable = 1'b0;
    for (int i = 1; i < 2*W; i++) step();
    step();
    chk({tag, ".pre_done"}, 32'(done), 0);
    step();
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".r"}, 32'(r), 32'(er));
    chk({tag, ".err"}, 32'(err), 32'(pv == '0));
    if (!pulse) begin
      step();
      chk({tag, ".hold"}, 32'(done), 1);
      chk({tag, ".hold_r"}, 32'(r), 32'(er));
      enable = 1'b0;
    end
    step();
    chk({tag, ".drop"}, 32'(done), 0);
    chk({tag, ".kept_r"}, 32'(r), 32'(er));
    step();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    x      = '0;
    p      = '0;
    step();
    step();
    chk("rst.done", 32'(done), 0);
    chk("rst.r", 32'(r), 0);
    chk("rst.err", 32'(err), 0);
    reset = 1'b0;
    step();

    run(32'sd56088, 16'd37, 1'b0, "pos");
    chk("pos.lit", 32'(r), 33);
    run(-32'sd56088, 16'd37, 1'b0, "neg");
    chk("neg.lit", 32'(r), 4);
    run(-32'sd37, 16'd37, 1'b0, "negzero");
    run(32'h8000_0000, 16'd65521, 1'b0, "minint");
    chk("minint.lit", 32'(r), 32648);
    run(32'd0, 16'd65521, 1'b0, "zero");
    run(32'hDEAD_BEEF, 16'd1, 1'b0, "p1");
    run(32'd5, 16'd0, 1'b0, "p0");
    chk("p0.err_lit", 32'(err), 1);
    run(32'd20, 16'd7, 1'b0, "after_err");
    chk("after_err.lit", 32'(r), 6);

    // Reset ten cycles into an operation.
    x = 32'd1000;
    p = 16'd3;
    enable = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset  = 1'b0;
    enable = 1'b0;
    chk("midrst.done", 32'(done), 0);
    chk("midrst.r", 32'(r), 0);
    step();
    step();
    chk("midrst.idle", 32'(done), 0);
    run(32'd1000, 16'd3, 1'b0, "post_rst");

    run(32'hFFFF_1234, 16'd997, 1'b1, "pulse");

    for (int n = 0; n < 20; n++) begin
      logic [2*W-1:0] rx;
      logic [W-1:0]   rp;
      rx = $urandom;
      rp = W'($urandom_range(1, 65535));
      if (n % 5 == 4) rp = W'($urandom_range(1, 40));
      run(rx, rp, bit'(n % 3 == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
